// File: rtl/error_report_arbiter.sv
// error_report_arbiter: round-robin arbiter that shares the error FIFO write
// port among NREQ sources. Each source has a one-entry holding register and
// backpressure flag. Records that arrive while a source is busy are dropped
// and counted as lost.
module error_report_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int CW   = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NREQ-1:0]    STB,
  input  logic [NREQ*DW-1:0] ECD,
  output logic [NREQ-1:0]    BUSY,
  input  logic               WREADY,
  output logic               WSTB,
  output logic [DW-1:0]      WDATA,
  output logic [2:0]         WSRC,
  output logic [NREQ-1:0]    LOST,
  output logic [CW-1:0]      LOSTCNT,
  input  logic               LOSTCLR
);

  logic [NREQ-1:0]         pend;
  logic [NREQ-1:0][DW-1:0] hold;
  logic [2:0]              last;
  logic [NREQ-1:0]         gnt;
  logic [2:0]              gidx;
  logic [NREQ-1:0]         drop;
  logic [3:0]              ndrop;
  logic [CW+3:0]           cnt_sum;

  // Round-robin search: first pending source after the last one issued.
  always_comb begin
    gnt  = '0;
    gidx = '0;
    if (WREADY && |pend) begin
      for (int k = NREQ; k >= 1; k--) begin
        // iterate backwards so the closest candidate (smallest k) wins
        if (pend[(int'(last) + k) % NREQ]) begin
          gidx = 3'((int'(last) + k) % NREQ);
        end
      end
      gnt[gidx] = 1'b1;
    end
  end

  // A granted source frees its slot this cycle, so a same-cycle strobe is taken.
  assign BUSY = pend & ~gnt;
  assign drop = STB & BUSY;

  // Number of records dropped this cycle, widened for a saturating add.
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NREQ; i++) ndrop = ndrop + 4'(drop[i]);
    cnt_sum = (CW+4)'(LOSTCNT) + (CW+4)'(ndrop);
  end

  // Per-source capture: an issue clears PEND, a fresh accepted strobe sets it again.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend <= '0;
      hold <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (STB[i] && !BUSY[i]) begin
          hold[i] <= ECD[i*DW +: DW];
          pend[i] <= 1'b1;
        end else if (gnt[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Issue the granted record to the FIFO; outputs hold their value when idle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      WSTB  <= 1'b0;
      WDATA <= '0;
      WSRC  <= '0;
      last  <= 3'(NREQ-1);
    end else if (|gnt) begin
      WSTB  <= 1'b1;
      WDATA <= hold[gidx];
      WSRC  <= gidx;
      last  <= gidx;
    end else begin
      WSTB  <= 1'b0;
    end
  end

  // Lost-record bookkeeping; a clear wins over any same-cycle drop.
  always_ff @(posedge CLK) begin
    if (RESET || LOSTCLR) begin
      LOST    <= '0;
      LOSTCNT <= '0;
    end else begin
      LOST <= LOST | drop;
      if (cnt_sum > (CW+4)'({CW{1'b1}})) LOSTCNT <= {CW{1'b1}};
      else                               LOSTCNT <= cnt_sum[CW-1:0];
    end
  end

endmodule

// File: tb/tb_error_report_arbiter.sv
// tb_error_report_arbiter: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of the arbiter.
module tb_error_report_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int CW   = 8;

  logic               CLK = 1'b0;
  logic               RESET;
  logic [NREQ-1:0]    STB;
  logic [NREQ*DW-1:0] ECD;
  logic [NREQ-1:0]    BUSY;
  logic               WREADY;
  logic               WSTB;
  logic [DW-1:0]      WDATA;
  logic [2:0]         WSRC;
  logic [NREQ-1:0]    LOST;
  logic [CW-1:0]      LOSTCNT;
  logic               LOSTCLR;

  error_report_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET), .STB(STB), .ECD(ECD), .BUSY(BUSY),
    .WREADY(WREADY), .WSTB(WSTB), .WDATA(WDATA), .WSRC(WSRC),
    .LOST(LOST), .LOSTCNT(LOSTCNT), .LOSTCLR(LOSTCLR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_pend [NREQ];
  logic [63:0] m_hold [NREQ];
  int          m_last;
  bit          m_lost [NREQ];
  int          m_cnt;
  bit          m_wstb;
  logic [63:0] m_wdata;
  int          m_wsrc;
  logic [63:0] dv [NREQ];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] lost_vec();
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i] = m_lost[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_pend[i] = 0; m_hold[i] = '0; m_lost[i] = 0;
    end
    m_last = NREQ-1; m_cnt = 0; m_wstb = 0; m_wdata = '0; m_wsrc = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; STB = '0; WREADY = 1'b1; LOSTCLR = 1'b0;
    @(posedge CLK); #1;
    model_reset();
    chk("rst_wstb", 64'(WSTB), 64'(0));
    chk("rst_wdata", WDATA, 64'h0);
    chk("rst_wsrc", 64'(WSRC), 64'(0));
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_lost", 64'(LOST), 64'(0));
    chk("rst_lostcnt", 64'(LOSTCNT), 64'(0));
  endtask

  // one clock cycle: drive, check BUSY, clock, advance model, check outputs
  task automatic step(input logic [NREQ-1:0] s, input logic w, input logic c);
    int g;
    int n;
    logic [NREQ-1:0] busy_m;
    @(negedge CLK);
    RESET = 1'b0; STB = s; WREADY = w; LOSTCLR = c;
    for (int i = 0; i < NREQ; i++) ECD[i*DW +: DW] = dv[i];
    #1;
    g = -1;
    if (w) begin
      for (int k = 1; k <= NREQ && g < 0; k++)
        if (m_pend[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
    end
    for (int i = 0; i < NREQ; i++) busy_m[i] = m_pend[i] && (i != g);
    chk("busy", 64'(BUSY), 64'(busy_m));
    @(posedge CLK); #1;
    n = 0;
    for (int i = 0; i < NREQ; i++) if (s[i] && busy_m[i]) n++;
    if (c) begin
      m_cnt = 0;
      for (int i = 0; i < NREQ; i++) m_lost[i] = 0;
    end else begin
      m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
      for (int i = 0; i < NREQ; i++) if (s[i] && busy_m[i]) m_lost[i] = 1;
    end
    m_wstb = (g >= 0);
    if (g >= 0) begin
      m_wdata = m_hold[g]; m_wsrc = g; m_last = g; m_pend[g] = 0;
    end
    for (int i = 0; i < NREQ; i++)
      if (s[i] && !busy_m[i]) begin
        m_hold[i] = dv[i]; m_pend[i] = 1;
      end
    chk("wstb", 64'(WSTB), 64'(m_wstb));
    chk("wdata", WDATA, m_wdata);
    chk("wsrc", 64'(WSRC), 64'(m_wsrc));
    chk("lost", 64'(LOST), 64'(lost_vec()));
    chk("lostcnt", 64'(LOSTCNT), 64'(m_cnt));
  endtask

  initial begin
    RESET = 1'b1; STB = '0; ECD = '0; WREADY = 1'b0; LOSTCLR = 1'b0;
    for (int i = 0; i < NREQ; i++) dv[i] = 64'(i + 16);
    do_reset();

    // single record: visible at t+2 only
    dv[2] = 64'hA5;
    step(4'b0100, 1'b1, 1'b0);
    chk("t1_early", 64'(WSTB), 64'(0));
    step(4'b0000, 1'b1, 1'b0);
    chk("t1_wstb", 64'(WSTB), 64'(1));
    chk("t1_wdata", WDATA, 64'hA5);
    chk("t1_wsrc", 64'(WSRC), 64'(2));
    step(4'b0000, 1'b1, 1'b0);
    chk("t1_once", 64'(WSTB), 64'(0));

    // round robin, two bursts
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NREQ; i++) dv[i] = 64'(100*b + i + 1);
      step(4'b1111, 1'b1, 1'b0);
      for (int k = 0; k < NREQ; k++) begin
        step(4'b0000, 1'b1, 1'b0);
        chk("rr_src", 64'(WSRC), 64'(k));
        chk("rr_data", WDATA, 64'(100*b + k + 1));
      end
    end

    // backpressure
    do_reset();
    step(4'b0101, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(4'b0000, 1'b0, 1'b0);
      chk("bp_busy", 64'(BUSY), 64'(4'b0101));
      chk("bp_wstb", 64'(WSTB), 64'(0));
    end
    step(4'b0000, 1'b1, 1'b0);
    chk("bp_src0", 64'(WSRC), 64'(0));
    step(4'b0000, 1'b1, 1'b0);
    chk("bp_src2", 64'(WSRC), 64'(2));

    // drop while busy
    do_reset();
    dv[1] = 64'h1111;
    step(4'b0010, 1'b0, 1'b0);
    dv[1] = 64'h2222;
    step(4'b0010, 1'b0, 1'b0);
    chk("drop_lost", 64'(LOST), 64'(4'b0010));
    chk("drop_cnt", 64'(LOSTCNT), 64'(1));
    step(4'b0000, 1'b1, 1'b0);
    chk("drop_data", WDATA, 64'h1111);

    // strobe in the grant cycle
    do_reset();
    dv[3] = 64'hAAAA;
    step(4'b1000, 1'b1, 1'b0);
    dv[3] = 64'hBBBB;
    step(4'b1000, 1'b1, 1'b0);
    chk("col_x", WDATA, 64'hAAAA);
    step(4'b0000, 1'b1, 1'b0);
    chk("col_y", WDATA, 64'hBBBB);
    chk("col_cnt", 64'(LOSTCNT), 64'(0));

    // saturation, then clear beating a drop
    do_reset();
    for (int k = 0; k < 76; k++) step(4'b1111, 1'b0, 1'b0);
    chk("sat_cnt", 64'(LOSTCNT), 64'(255));
    step(4'b1111, 1'b0, 1'b1);
    chk("clr_cnt", 64'(LOSTCNT), 64'(0));
    chk("clr_lost", 64'(LOST), 64'(0));

    // reset with records pending: nothing issued afterwards
    do_reset();
    step(4'b0000, 1'b1, 1'b0);
    chk("midrst_wstb", 64'(WSTB), 64'(0));

    // random traffic
    for (int k = 0; k < 2000; k++) begin
      logic [NREQ-1:0] s;
      for (int i = 0; i < NREQ; i++) dv[i] = {$urandom, $urandom};
      s = NREQ'($urandom) & NREQ'($urandom);
      step(s, ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
